pipe_skid_stage: RTL
====================

// Module: pipe_skid_stage
// PURPOSE
//  Generic elastic pipeline-stage register for the lc3b pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Replaces the fixed-field load/reset stage registers with one packed payload of parameterised width.
//  Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready has no combinational path from downstream.
//  Also provides a synchronous flush for branch mispredicts and a saturating stall-cycle counter.
// PARAMETERS
//  WIDTH      16  payload bits (control word, PC, operands, prediction info packed by the caller)
//  CNT_WIDTH  16  width of the stall-cycle counter
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          synchronous, active-high reset
//  flush        in   1          synchronous kill of all held entries (mispredict/trap)
//  in_valid     in   1          upstream payload valid
//  in_data      in   WIDTH      upstream payload
//  in_ready     out  1          stage can accept a beat this cycle
//  out_valid    out  1          downstream payload valid
//  out_data     out  WIDTH      downstream payload
//  out_ready    in   1          downstream accepts a beat this cycle
//  occupancy    out  2          entries held (0..2)
//  stall_cnt_clr in  1          clear the stall counter
//  stall_cnt    out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  Storage: main entry (drives out_*) and skid entry. State is encoded as EMPTY / ONE / TWO.
//  Combinational outputs:
//   in_ready  = (state != TWO)       -- register-only, no dependence on out_ready
//   out_valid = (state != EMPTY)
//   out_data  = main data when out_valid, else all zeros
//   occupancy = 0 / 1 / 2 for EMPTY / ONE / TWO
//  acc = in_valid & in_ready;  drn = out_valid & out_ready.
//  Transitions (edge N; result visible in cycle N+1):
//   EMPTY: acc -> ONE, main<=in_data; otherwise stay EMPTY
//   ONE:   acc&drn -> ONE, main<=in_data
//          acc&!drn -> TWO, skid<=in_data
//          !acc&drn -> EMPTY
//          otherwise hold
//   TWO:   drn -> ONE, main<=skid; otherwise hold (in_ready=0, so acc is impossible)
//  Latency: 1 cycle from acceptance to out_valid when the stage is empty. Throughput is 1 beat/cycle.
//  Ordering: beats leave strictly in acceptance order; nothing is duplicated or dropped unless flushed.
//  Priority: reset > flush > normal operation.
//   flush: next state EMPTY. A beat accepted in the flush cycle is discarded. A beat drained in the
//   flush cycle counts as delivered. Stored data registers may keep stale values; out_data still reads 0.
//   reset: state EMPTY, main/skid data = 0, stall_cnt = 0. Reset asserted mid-transfer drops both entries.
//  Stall counter:
//   +1 each cycle with out_valid & !out_ready; saturates at 2^CNT_WIDTH-1 (no wrap).
//   stall_cnt_clr sets it to 0 and takes priority over increment; flush does not clear it.
//  Hold with out_ready=0 keeps main/skid bit-stable regardless of in_data changes.
//  All state updates on posedge clk only; no latches, no initial blocks relied upon.
// TESTING
//  1. reset 1 cycle -> out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
//  2. stream 0x1111,0x2222,0x3333 with out_ready=1 -> outputs appear in cycles 1,2,3 in order; occupancy stays 1.
//  3. out_ready=0, push 0xAAAA,0xBBBB -> occupancy=2, in_ready=0, out_data=0xAAAA held;
//     out_ready=1 -> 0xAAAA then 0xBBBB, in_ready=1 again one cycle after the first drain.
//  4. occupancy=2 and flush with in_valid=1 (0xCCCC) -> next cycle out_valid=0, occupancy=0; 0xCCCC never emitted.
//  5. CNT_WIDTH=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds;
//     stall_cnt_clr -> 0 next cycle.
//  6. random in_valid/out_ready for 10k cycles with a scoreboard -> no loss, duplication or reorder;
//     in_ready never depends on out_ready in the same cycle.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, synchronous flush
// and a saturating stall-cycle counter. in_ready is a pure function of state.
module pipe_skid_stage #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [1:0]           occupancy,
    input  logic                 stall_cnt_clr,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             main_ld, main_from_skid, skid_ld;
    logic             acc, drn;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = out_valid ? main_q : '0;
    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;

    always_comb begin
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (flush) begin
            // Data registers are left stale; out_data is masked while EMPTY.
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt = ONE;
                        main_ld   = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        main_ld = 1'b1;
                    end else if (acc) begin
                        state_nxt = TWO;
                        skid_ld   = 1'b1;
                    end else if (drn) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (drn) begin
                        state_nxt      = ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (main_ld)
                main_q <= main_from_skid ? skid_q : in_data;
            if (skid_ld)
                skid_q <= in_data;
        end
    end

    // Counts stalled cycles, including a flush cycle that is also stalled.
    always_ff @(posedge clk) begin
        if (reset || stall_cnt_clr)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != {CNT_WIDTH{1'b1}}))
            stall_cnt <= stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

endmodule
